// File: rtl/jtframe_ioctl_pkg.sv
// Shared definitions for the ioctl transmitter: FSM state encoding and
// default timing constants.
package jtframe_ioctl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DL_WAIT = 3'd1,
        DL_WR   = 3'd2,
        DL_GAP  = 3'd3,
        FINISH  = 3'd4,
        UL_ADDR = 3'd5,
        UL_LAT  = 3'd6,
        UL_SEND = 3'd7
    } state_t;

    localparam int DEF_WR_GAP = 4;
    localparam int DEF_RD_LAT = 2;

    // Width of the shared gap/latency counter; WR_GAP and RD_LAT must fit.
    localparam int CNT_W = 8;

endpackage

// File: rtl/jtframe_ioctl_tx.sv
// jtframe_ioctl_tx: host byte stream -> paced ioctl writes (download), and
// paced ioctl reads -> host byte stream (NVRAM upload).
// Optional macro JTFRAME_IOCTL_TX_CHKSUM_EN adds a running modulo-256 sum of
// every byte moved; without it the chksum port is tied to zero.
module jtframe_ioctl_tx
    import jtframe_ioctl_pkg::*;
#(
    parameter int AW     = 25,
    parameter int WR_GAP = DEF_WR_GAP,
    parameter int RD_LAT = DEF_RD_LAT,
    parameter int LW     = 16
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          dl_start,
    input  logic          dl_ram,
    input  logic          ul_start,
    input  logic [LW-1:0] ul_len,
    input  logic          abort,
    input  logic [7:0]    s_data,
    input  logic          s_valid,
    input  logic          s_last,
    output logic          s_ready,
    output logic [7:0]    m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          done,
    output logic          busy,
    output logic          downloading,
    output logic [AW-1:0] ioctl_addr,
    output logic [7:0]    ioctl_dout,
    output logic          ioctl_wr,
    output logic          ioctl_ram,
    input  logic [7:0]    ioctl_din,
    input  logic          dwnld_busy,
    output logic [7:0]    chksum
);

    // DL_GAP lasts WR_GAP-1 cycles, UL_LAT lasts RD_LAT cycles.
    localparam logic [CNT_W-1:0] GAP_END = CNT_W'(WR_GAP - 2);
    localparam logic [CNT_W-1:0] LAT_END = CNT_W'(RD_LAT - 1);

    state_t            state_r;
    state_t            next_state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [LW-1:0]     len_r;
    logic              last_r;

    logic dl_go_s;
    logic ul_go_s;
    logic accept_s;
    logic gap_done_s;
    logic lat_done_s;
    logic ul_hs_s;
    logic in_xfer_s;

    // Decode the events that drive both the FSM and the datapath.
    always_comb begin
        dl_go_s    = (state_r == IDLE) && dl_start;
        ul_go_s    = (state_r == IDLE) && ul_start && !dl_start;
        // abort wins over a byte offered in the same cycle
        accept_s   = s_ready && s_valid && !abort;
        gap_done_s = (state_r == DL_GAP) && (cnt_r == GAP_END);
        lat_done_s = (state_r == UL_LAT) && (cnt_r == LAT_END);
        ul_hs_s    = (state_r == UL_SEND) && m_ready && !abort;
        in_xfer_s  = (state_r != IDLE) && (state_r != FINISH);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; abort sends every active transfer to FINISH.
    always_comb begin
        next_state_s = state_r;
        if (in_xfer_s && abort) begin
            next_state_s = FINISH;
        end else begin
            case (state_r)
                IDLE: begin
                    if (dl_start) begin
                        next_state_s = DL_WAIT;
                    end else if (ul_start) begin
                        next_state_s = (ul_len == {LW{1'b0}}) ? FINISH : UL_ADDR;
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                DL_WAIT: next_state_s = accept_s ? DL_WR : DL_WAIT;
                DL_WR:   next_state_s = DL_GAP;
                DL_GAP: begin
                    if (gap_done_s) begin
                        next_state_s = last_r ? FINISH : DL_WAIT;
                    end else begin
                        next_state_s = DL_GAP;
                    end
                end
                FINISH:  next_state_s = dwnld_busy ? FINISH : IDLE;
                UL_ADDR: next_state_s = UL_LAT;
                UL_LAT:  next_state_s = lat_done_s ? UL_SEND : UL_LAT;
                UL_SEND: begin
                    if (ul_hs_s) begin
                        next_state_s = (len_r == LW'(1)) ? FINISH : UL_ADDR;
                    end else begin
                        next_state_s = UL_SEND;
                    end
                end
                default: next_state_s = IDLE;
            endcase
        end
    end

    // Datapath: timing counter, address, latched bytes and upload count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r      <= {CNT_W{1'b0}};
            ioctl_addr <= {AW{1'b0}};
            ioctl_dout <= 8'd0;
            last_r     <= 1'b0;
            len_r      <= {LW{1'b0}};
            m_data     <= 8'd0;
        end else begin
            // counter restarts on every state change
            cnt_r <= (next_state_s != state_r) ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);

            if (dl_go_s || ul_go_s) begin
                ioctl_addr <= {AW{1'b0}};
            end else if ((gap_done_s && !abort) || ul_hs_s) begin
                ioctl_addr <= ioctl_addr + AW'(1);
            end

            if (accept_s) begin
                ioctl_dout <= s_data;
                last_r     <= s_last;
            end

            if (ul_go_s) begin
                len_r <= ul_len;
            end else if (ul_hs_s) begin
                len_r <= len_r - LW'(1);
            end

            if (lat_done_s && !abort) begin
                m_data <= ioctl_din;
            end
        end
    end

    // Registered control outputs, all derived from the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ready     <= 1'b0;
            ioctl_wr    <= 1'b0;
            m_valid     <= 1'b0;
            downloading <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ioctl_ram   <= 1'b0;
        end else begin
            s_ready     <= (next_state_s == DL_WAIT);
            ioctl_wr    <= (next_state_s == DL_WR);
            m_valid     <= (next_state_s == UL_SEND);
            downloading <= (next_state_s == DL_WAIT) || (next_state_s == DL_WR) ||
                           (next_state_s == DL_GAP);
            busy        <= (next_state_s != IDLE);
            done        <= (state_r == FINISH) && !dwnld_busy;

            if ((next_state_s == FINISH) || (next_state_s == IDLE)) begin
                ioctl_ram <= 1'b0;
            end else if (dl_go_s) begin
                ioctl_ram <= dl_ram;
            end else if (ul_go_s) begin
                ioctl_ram <= 1'b1;
            end
        end
    end

`ifdef JTFRAME_IOCTL_TX_CHKSUM_EN
    // Running sum of bytes written to the game or handed to the host.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chksum <= 8'd0;
        end else if (dl_go_s || ul_go_s) begin
            chksum <= 8'd0;
        end else if (state_r == DL_WR) begin
            chksum <= chksum + ioctl_dout;
        end else if (ul_hs_s) begin
            chksum <= chksum + m_data;
        end
    end
`else
    assign chksum = 8'd0;
`endif

endmodule

// File: tb/tb_jtframe_ioctl_tx.sv
// Self-checking bench for jtframe_ioctl_tx: randomized downloads/uploads,
// expected writes and upload bytes queued by the stimulus and checked by a
// separate monitor on the falling clock edge.
module tb_jtframe_ioctl_tx;

    localparam int AW     = 25;
    localparam int WR_GAP = 4;
    localparam int RD_LAT = 2;
    localparam int LW     = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dl_start = 1'b0;
    logic          dl_ram = 1'b0;
    logic          ul_start = 1'b0;
    logic [LW-1:0] ul_len = '0;
    logic          abort = 1'b0;
    logic [7:0]    s_data = 8'd0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic [7:0]    m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          done;
    logic          busy;
    logic          downloading;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic          ioctl_wr;
    logic          ioctl_ram;
    logic [7:0]    ioctl_din;
    logic          dwnld_busy = 1'b0;
    logic [7:0]    chksum;

    jtframe_ioctl_tx #(.AW(AW), .WR_GAP(WR_GAP), .RD_LAT(RD_LAT), .LW(LW)) dut (
        .clk(clk), .rst(rst), .dl_start(dl_start), .dl_ram(dl_ram),
        .ul_start(ul_start), .ul_len(ul_len), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .done(done), .busy(busy), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
        .ioctl_ram(ioctl_ram), .ioctl_din(ioctl_din), .dwnld_busy(dwnld_busy),
        .chksum(chksum)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Game-side NVRAM model: data = addr ^ 0xA5, valid RD_LAT cycles after addr.
    logic [7:0] din_pipe [RD_LAT];
    always @(posedge clk) begin
        din_pipe[0] <= ioctl_addr[7:0] ^ 8'hA5;
        for (int i = 1; i < RD_LAT; i++) din_pipe[i] <= din_pipe[i-1];
    end
    assign ioctl_din = din_pipe[RD_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] up_q[$];
    logic [7:0] dl_bytes[$];
    wr_t        mon_w;
    logic [7:0] mon_b;
    logic [7:0] prev_mdata = 8'd0;
    bit         prev_hold = 1'b0;
    bit         exp_ram = 1'b0;
    int         last_wr = -1;
    int         wr_cnt = 0;
    int         done_cnt = 0;
    int         mv_cnt = 0;

    // Monitor: checks every write strobe and upload handshake against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (ioctl_wr) begin
                wr_cnt++;
                if (wr_q.size() == 0) begin
                    chk("unexpected_wr", 32'(ioctl_addr), 32'hFFFF_FFFF);
                end else begin
                    mon_w = wr_q.pop_front();
                    chk("wr_addr", 32'(ioctl_addr), 32'(mon_w.addr));
                    chk("wr_data", 32'(ioctl_dout), 32'(mon_w.data));
                end
                chk("wr_ram", 32'(ioctl_ram), 32'(exp_ram));
                if (last_wr >= 0) chk("wr_spacing", 32'((cyc - last_wr) >= WR_GAP + 1), 32'd1);
                last_wr = cyc;
            end
            if (m_valid) begin
                mv_cnt++;
                if (prev_hold) chk("m_data_hold", 32'(m_data), 32'(prev_mdata));
                if (m_ready) begin
                    if (up_q.size() == 0) begin
                        chk("unexpected_ul", 32'(m_data), 32'hFFFF_FFFF);
                    end else begin
                        mon_b = up_q.pop_front();
                        chk("ul_data", 32'(m_data), 32'(mon_b));
                    end
                    chk("ul_ram", 32'(ioctl_ram), 32'd1);
                end
                prev_hold  = !m_ready;
                prev_mdata = m_data;
            end else begin
                prev_hold = 1'b0;
            end
            if (s_ready) chk("s_ready_ctx", 32'({downloading, ioctl_wr, m_valid}), 32'b100);
            if (done) done_cnt++;
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold dwnld_busy for 'hold' cycles in FINISH, then expect a done pulse.
    task automatic finish_seq(input int hold);
        int d0;
        d0 = done_cnt;
        repeat (hold) tick();
        chk("done_early", 32'(done_cnt - d0), 32'd0);
        chk("finish_ram", 32'(ioctl_ram), 32'd0);
        dwnld_busy = 1'b0;
        tick();
        chk("done_timing", 32'(done), 32'd1);
        tick();
        chk("done_pulse_width", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic download(input bit ram_sel, input bit rnd_valid, input int abort_after);
        int n;
        int t;
        int w0;
        bit acc;
        logic [7:0] sum;
        wr_t w;
        n = dl_bytes.size();
        exp_ram = ram_sel;
        last_wr = -1;
        sum = 8'd0;
        w0 = wr_cnt;
        for (int i = 0; i < n; i++) begin
            if (abort_after < 0 || i < abort_after) begin
                w.addr = AW'(i);
                w.data = dl_bytes[i];
                wr_q.push_back(w);
                sum = sum + dl_bytes[i];
            end
        end
        dwnld_busy = 1'b1;
        dl_ram = ram_sel;
        dl_start = 1'b1;
        tick();
        dl_start = 1'b0;
        chk("dl_downloading", 32'(downloading), 32'd1);
        chk("dl_ram_sel", 32'(ioctl_ram), 32'(ram_sel));
        chk("dl_addr0", 32'(ioctl_addr), 32'd0);
        for (int i = 0; i < n; i++) begin
            if (abort_after >= 0 && i >= abort_after) break;
            s_data = dl_bytes[i];
            s_last = (i == n - 1);
            acc = 1'b0;
            t = 0;
            while (!acc && t < 200) begin
                s_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
                acc = s_valid && s_ready;
                tick();
                t++;
            end
            s_valid = 1'b0;
            if (!acc) chk("dl_accept_timeout", 32'd0, 32'd1);
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        if (abort_after >= 0) begin
            t = 0;
            while (wr_q.size() != 0 && t < 100) begin tick(); t++; end
            abort = 1'b1;
            tick();
            abort = 1'b0;
            chk("abort_downloading", 32'(downloading), 32'd0);
            repeat (WR_GAP + 3) tick();
            chk("abort_wr_count", 32'(wr_cnt - w0), 32'(abort_after));
        end
        t = 0;
        while (downloading && t < 100) begin tick(); t++; end
        chk("dl_end", 32'(downloading), 32'd0);
        chk("dl_all_written", 32'(wr_q.size()), 32'd0);
        finish_seq(10);
`ifdef JTFRAME_IOCTL_TX_CHKSUM_EN
        chk("dl_chksum", 32'(chksum), 32'(sum));
`else
        chk("dl_chksum_tied", 32'(chksum), 32'd0);
`endif
    endtask

    task automatic upload(input int len, input int bp, input bit rnd);
        int d0;
        int mv0;
        int t;
        int hold;
        logic [7:0] sum;
        logic [7:0] b;
        sum = 8'd0;
        for (int i = 0; i < len; i++) begin
            b = 8'(i) ^ 8'hA5;
            up_q.push_back(b);
            sum = sum + b;
        end
        dwnld_busy = 1'b0;
        d0 = done_cnt;
        mv0 = mv_cnt;
        ul_len = LW'(len);
        ul_start = 1'b1;
        tick();
        ul_start = 1'b0;
        if (len > 0) chk("ul_ram_start", 32'(ioctl_ram), 32'd1);
        t = 0;
        hold = 0;
        while (done_cnt == d0 && t < 1000) begin
            if (m_valid) begin
                if (hold < bp || (rnd && $urandom_range(0, 2) == 0)) begin
                    m_ready = 1'b0;
                    hold++;
                end else begin
                    m_ready = 1'b1;
                end
            end else begin
                m_ready = 1'b0;
                hold = 0;
            end
            tick();
            t++;
        end
        m_ready = 1'b0;
        chk("ul_done_seen", 32'(done_cnt - d0), 32'd1);
        chk("ul_all_sent", 32'(up_q.size()), 32'd0);
        chk("ul_ram_after", 32'(ioctl_ram), 32'd0);
        if (len == 0) begin
            chk("ul0_latency", 32'(t <= 2), 32'd1);
            chk("ul0_no_mvalid", 32'(mv_cnt - mv0), 32'd0);
        end
`ifdef JTFRAME_IOCTL_TX_CHKSUM_EN
        chk("ul_chksum", 32'(chksum), 32'(sum));
`else
        chk("ul_chksum_tied", 32'(chksum), 32'd0);
`endif
    endtask

    initial begin
        int t;
        int d0;
        int n;
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", 32'({s_ready, m_valid, done, busy, downloading, ioctl_wr, ioctl_ram}), 32'd0);
        chk("rst_addr", 32'(ioctl_addr), 32'd0);
        chk("rst_data", 32'({m_data, ioctl_dout, chksum}), 32'd0);
        rst = 1'b0;
        tick();

        // fixed 4-byte download
        dl_bytes = {8'h11, 8'h22, 8'h33, 8'h44};
        download(1'b0, 1'b0, -1);

        // random downloads with random s_valid
        for (int k = 0; k < 4; k++) begin
            dl_bytes.delete();
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) dl_bytes.push_back(8'($urandom));
            download(1'($urandom_range(0, 1)), 1'b1, -1);
        end

        // uploads: fixed with 5-cycle backpressure, random, empty
        upload(3, 5, 1'b0);
        upload($urandom_range(1, 6), 0, 1'b1);
        upload($urandom_range(1, 6), 1, 1'b1);
        upload(0, 0, 1'b0);

        // simultaneous starts: download wins
        dwnld_busy = 1'b1;
        dl_ram = 1'b0;
        ul_len = LW'(5);
        dl_start = 1'b1;
        ul_start = 1'b1;
        tick();
        dl_start = 1'b0;
        ul_start = 1'b0;
        chk("both_downloading", 32'(downloading), 32'd1);
        chk("both_ram", 32'(ioctl_ram), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("both_abort", 32'(downloading), 32'd0);
        finish_seq(2);

        // abort after 2 of 5 bytes
        dl_bytes = {8'h5A, 8'hC3, 8'h01, 8'h02, 8'h03};
        download(1'b1, 1'b0, 2);

        // abort in idle is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle_busy", 32'(busy), 32'd0);

        // asynchronous reset mid-upload
        for (int i = 0; i < 4; i++) up_q.push_back(8'(i) ^ 8'hA5);
        ul_len = LW'(4);
        ul_start = 1'b1;
        tick();
        ul_start = 1'b0;
        t = 0;
        while (!m_valid && t < 50) begin tick(); t++; end
        chk("rst_mid_mvalid", 32'(m_valid), 32'd1);
        d0 = done_cnt;
        #3 rst = 1'b1;
        #1;
        chk("rst_mid_ctrl", 32'({s_ready, m_valid, done, busy, downloading, ioctl_wr, ioctl_ram}), 32'd0);
        chk("rst_mid_addr", 32'(ioctl_addr), 32'd0);
        chk("rst_mid_data", 32'({m_data, ioctl_dout, chksum}), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        up_q.delete();
        repeat (10) tick();
        chk("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
        chk("rst_mid_idle", 32'(busy), 32'd0);

        // checksum wrap case
        dl_bytes = {8'hFF, 8'h02};
        download(1'b0, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
